ps2_key_event_ctrl: RTL

Controller between the PS/2 byte receiver and the CPU's memory-mapped I/O bus. It consumes received scancode bytes and receiver errors. It folds the set-2 prefix sequences (E0, F0, E0 F0) into single key events and queues them in a FIFO. It exposes data/status/control registers with pop-on-read and a level interrupt.

---
 rtl/ps2_kbd_pkg.sv | 32 +++
 rtl/kbd_event_fifo.sv | 63 ++++++
 rtl/ps2_key_event_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg
// Shared types and constants for the PS/2 key event controller:
//   - decoder state encoding
//   - set-2 prefix / keyboard overrun byte values
//   - register word addresses
//   - packed key event record {ext, rel, code}
package ps2_kbd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } kbd_state_e;

    localparam logic [7:0] PFX_EXT  = 8'hE0;
    localparam logic [7:0] PFX_BRK  = 8'hF0;
    localparam logic [7:0] KBD_OVR0 = 8'h00;
    localparam logic [7:0] KBD_OVR1 = 8'hFF;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    // 'rel' is the break (key release) flag; 'release' is a reserved word.
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo
// Synchronous FIFO for key events. Head entry is readable without a pop.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push_i/data_i  : write request and data
//   pop_i          : read request (ignored when empty)
//   head_o         : oldest entry (valid while !empty_o)
//   full_o/empty_o : occupancy flags
//   count_o        : number of entries held
//   drop_o         : pulses when a push is rejected because the FIFO is full
module kbd_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & ~push_ok;
    assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Folds PS/2 set-2 scancode bytes (E0 / F0 / E0 F0 prefixes) into key events,
// queues them, and exposes them through a small memory-mapped register file.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   scancode_i, scancode_valid_i    : received byte and its strobe
//   rx_error_i                      : receiver framing/parity error strobe
//   bus_addr_i, bus_rd_i, bus_wr_i  : register word address and strobes
//   bus_wdata_i, bus_rdata_o        : write data, combinational read data
//   irq_o                           : level interrupt (irq_en & not_empty)
module ps2_key_event_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int PREFIX_TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  scancode_i,
    input  logic        scancode_valid_i,
    input  logic        rx_error_i,
    input  logic [1:0]  bus_addr_i,
    input  logic        bus_rd_i,
    input  logic        bus_wr_i,
    input  logic [31:0] bus_wdata_i,
    output logic [31:0] bus_rdata_o,
    output logic        irq_o
);
    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
    localparam int EW = $bits(key_event_t);

    kbd_state_e        state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [7:0]        err_cnt_q;
    logic              overflow_q;
    logic              irq_en_q;

    logic              push;
    key_event_t        push_ev;
    logic              err_inc;
    logic              timeout;

    logic [EW-1:0]     fifo_head;
    key_event_t        head_ev;
    logic              fifo_full, fifo_empty, fifo_drop, fifo_pop;
    logic [$clog2(DEPTH):0] fifo_count;

    logic              wr_status, wr_ctrl;
    logic              unused_wdata;

    assign timeout = (state_q != IDLE) && (tmo_q == TW'(PREFIX_TIMEOUT - 1));

    // Decoder: receiver error beats a coincident byte; a byte beats timeout.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        push_ev = '{ext: 1'b0, rel: 1'b0, code: scancode_i};
        err_inc = 1'b0;
        if (rx_error_i) begin
            state_d = IDLE;
            err_inc = 1'b1;
        end else if (scancode_valid_i) begin
            unique case (state_q)
                IDLE: begin
                    if (scancode_i == PFX_EXT) begin
                        state_d = GOT_E0;
                    end else if (scancode_i == PFX_BRK) begin
                        state_d = GOT_F0;
                    end else if (scancode_i == KBD_OVR0 || scancode_i == KBD_OVR1) begin
                        err_inc = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                GOT_E0: begin
                    if (scancode_i == PFX_BRK) begin
                        state_d = GOT_E0F0;
                    end else if (scancode_i != PFX_EXT) begin
                        push        = 1'b1;
                        push_ev.ext = 1'b1;
                        state_d     = IDLE;
                    end
                end
                GOT_F0, GOT_E0F0: begin
                    state_d = IDLE;
                    if (scancode_i == PFX_EXT || scancode_i == PFX_BRK) begin
                        err_inc = 1'b1;
                    end else begin
                        push        = 1'b1;
                        push_ev.ext = (state_q == GOT_E0F0);
                        push_ev.rel = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
        end
    end

    // Timeout counter only runs while waiting in a prefix state.
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (scancode_valid_i || rx_error_i || state_q == IDLE || timeout) begin
            tmo_d = '0;
        end
    end

    assign wr_status = bus_wr_i && (bus_addr_i == ADDR_STATUS);
    assign wr_ctrl   = bus_wr_i && (bus_addr_i == ADDR_CTRL);
    assign fifo_pop  = bus_rd_i && (bus_addr_i == ADDR_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            err_cnt_q  <= '0;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            // Set/increment take priority over a software clear.
            if (err_inc) begin
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end else if (wr_status && bus_wdata_i[8]) begin
                err_cnt_q <= '0;
            end
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end else if (wr_status && bus_wdata_i[1]) begin
                overflow_q <= 1'b0;
            end
            if (wr_ctrl) irq_en_q <= bus_wdata_i[0];
        end
    end

    kbd_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_ev),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    assign head_ev = key_event_t'(fifo_head);

    always_comb begin
        bus_rdata_o = '0;
        unique case (bus_addr_i)
            ADDR_DATA: begin
                if (!fifo_empty) begin
                    bus_rdata_o = {1'b1, 21'd0, head_ev.ext, head_ev.rel, head_ev.code};
                end
            end
            ADDR_STATUS: begin
                bus_rdata_o = {8'd0, 8'(fifo_count), err_cnt_q, 5'd0,
                               fifo_full, overflow_q, ~fifo_empty};
            end
            ADDR_CTRL: bus_rdata_o = {31'd0, irq_en_q};
            default:   bus_rdata_o = '0;
        endcase
    end

    assign irq_o = irq_en_q & ~fifo_empty;

    assign unused_wdata = ^{bus_wdata_i[31:9], bus_wdata_i[7:2]};

endmodule
